// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath defaults and load-kind encodings used by the
// writeback stage load extractor.
package cpu_pkg;

   localparam int CPU_DATA_W = 32;
   localparam int CPU_REG_W  = 5;

   typedef enum logic [2:0] {
      LT_LW  = 3'd0,
      LT_LH  = 3'd1,
      LT_LHU = 3'd2,
      LT_LB  = 3'd3,
      LT_LBU = 3'd4
   } load_type_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO queueing muldiv results until the register-file write port is free.
// Push is ignored when full, pop is ignored when empty.
module wb_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 37
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is not reset; an entry is only read after being written, so only pointers need reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: sole driver of the register-file write port, arbitrating MEM results
// (priority) over queued muldiv results. Optional early forwarding under WB_BYPASS_EN.
module writeback_stage
   import cpu_pkg::*;
#(
   parameter int DATA_W     = CPU_DATA_W,
   parameter int REG_W      = CPU_REG_W,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            Mem_valid,
   input  logic                            Mem_RegWrite,
   input  logic                            Mem_MemtoReg,
   input  logic [2:0]                      Mem_LoadType,
   input  logic [1:0]                      Mem_Addr_lo,
   input  logic [REG_W-1:0]                Mem_rd,
   input  logic [DATA_W-1:0]               Mem_Result,
   input  logic [DATA_W-1:0]               Mem_ReadData,
   input  logic                            Md_valid,
   output logic                            Md_ready,
   input  logic [REG_W-1:0]                Md_rd,
   input  logic [DATA_W-1:0]               Md_data,
   output logic [$clog2(FIFO_DEPTH):0]     Md_pending,
`ifdef WB_BYPASS_EN
   output logic                            Fwd_valid,
   output logic [REG_W-1:0]                Fwd_register,
   output logic [DATA_W-1:0]               Fwd_data,
`endif
   output logic                            Write,
   output logic [REG_W-1:0]                Write_register,
   output logic [DATA_W-1:0]               Write_data
);

   localparam int ENTRY_W = REG_W + DATA_W;

   logic               cand_valid;
   logic [DATA_W-1:0]  cand_data;
   logic [DATA_W-1:0]  load_data;
   logic [7:0]         byte_sel;
   logic [15:0]        half_sel;
   logic               fifo_full;
   logic               fifo_empty;
   logic               md_push;
   logic               md_pop;
   logic [ENTRY_W-1:0] head;

   assign cand_valid = Mem_valid && Mem_RegWrite && (Mem_rd != '0);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      byte_sel  = Mem_ReadData[7:0];
      half_sel  = Mem_Addr_lo[1] ? Mem_ReadData[31:16] : Mem_ReadData[15:0];
      load_data = Mem_ReadData;
      case (Mem_Addr_lo)
         2'd1:    byte_sel = Mem_ReadData[15:8];
         2'd2:    byte_sel = Mem_ReadData[23:16];
         2'd3:    byte_sel = Mem_ReadData[31:24];
         default: byte_sel = Mem_ReadData[7:0];
      endcase
      case (Mem_LoadType)
         LT_LH:   load_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
         LT_LHU:  load_data = {{(DATA_W-16){1'b0}}, half_sel};
         LT_LB:   load_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
         LT_LBU:  load_data = {{(DATA_W-8){1'b0}}, byte_sel};
         default: load_data = Mem_ReadData;
      endcase
   end

   assign cand_data = Mem_MemtoReg ? load_data : Mem_Result;

   // Readiness depends on occupancy only; a same-cycle pop never frees a slot early.
   assign Md_ready = reset && !fifo_full;
   assign md_push  = Md_valid && Md_ready && (Md_rd != '0);
   assign md_pop   = !cand_valid && !fifo_empty;

   wb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (md_push),
      .pop   (md_pop),
      .din   ({Md_rd, Md_data}),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (Md_pending)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         Write          <= 1'b0;
         Write_register <= '0;
         Write_data     <= '0;
      end else if (cand_valid) begin
         Write          <= 1'b1;
         Write_register <= Mem_rd;
         Write_data     <= cand_data;
      end else if (!fifo_empty) begin
         Write          <= 1'b1;
         Write_register <= head[ENTRY_W-1:DATA_W];
         Write_data     <= head[DATA_W-1:0];
      end else begin
         Write          <= 1'b0;
      end
   end

`ifdef WB_BYPASS_EN
   assign Fwd_valid    = reset && (cand_valid || !fifo_empty);
   assign Fwd_register = cand_valid ? Mem_rd : head[ENTRY_W-1:DATA_W];
   assign Fwd_data     = cand_valid ? cand_data : head[DATA_W-1:0];
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: stimulus queues expected register writes,
// a negedge monitor pops and compares each observed write.
module tb_writeback_stage;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;

   logic              clk = 1'b0;
   logic              reset;
   logic              Mem_valid, Mem_RegWrite, Mem_MemtoReg;
   logic [2:0]        Mem_LoadType;
   logic [1:0]        Mem_Addr_lo;
   logic [REG_W-1:0]  Mem_rd;
   logic [DATA_W-1:0] Mem_Result, Mem_ReadData;
   logic              Md_valid, Md_ready;
   logic [REG_W-1:0]  Md_rd;
   logic [DATA_W-1:0] Md_data;
   logic [1:0]        Md_pending;
   logic              Write;
   logic [REG_W-1:0]  Write_register;
   logic [DATA_W-1:0] Write_data;
`ifdef WB_BYPASS_EN
   logic              Fwd_valid;
   logic [REG_W-1:0]  Fwd_register;
   logic [DATA_W-1:0] Fwd_data;
`endif

   int errors = 0;
   int checks = 0;
   logic [REG_W+DATA_W-1:0] sb [$];

   always #5 clk = ~clk;

   writeback_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .FIFO_DEPTH(2)) dut (
      .clk            (clk),
      .reset          (reset),
      .Mem_valid      (Mem_valid),
      .Mem_RegWrite   (Mem_RegWrite),
      .Mem_MemtoReg   (Mem_MemtoReg),
      .Mem_LoadType   (Mem_LoadType),
      .Mem_Addr_lo    (Mem_Addr_lo),
      .Mem_rd         (Mem_rd),
      .Mem_Result     (Mem_Result),
      .Mem_ReadData   (Mem_ReadData),
      .Md_valid       (Md_valid),
      .Md_ready       (Md_ready),
      .Md_rd          (Md_rd),
      .Md_data        (Md_data),
      .Md_pending     (Md_pending),
`ifdef WB_BYPASS_EN
      .Fwd_valid      (Fwd_valid),
      .Fwd_register   (Fwd_register),
      .Fwd_data       (Fwd_data),
`endif
      .Write          (Write),
      .Write_register (Write_register),
      .Write_data     (Write_data)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Every observed write must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (Write === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got rd=%0d data=%h expected no write",
                     Write_register, Write_data);
         end else begin
            check("wb_write", 64'({Write_register, Write_data}), 64'(sb.pop_front()));
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_mem(input logic v, input logic rw, input logic m2r, input logic [2:0] lt,
                          input logic [1:0] lo, input logic [REG_W-1:0] rd,
                          input logic [DATA_W-1:0] res, input logic [DATA_W-1:0] rdata,
                          input logic [DATA_W-1:0] exp);
      Mem_valid    = v;
      Mem_RegWrite = rw;
      Mem_MemtoReg = m2r;
      Mem_LoadType = lt;
      Mem_Addr_lo  = lo;
      Mem_rd       = rd;
      Mem_Result   = res;
      Mem_ReadData = rdata;
      if (v && rw && rd != '0) sb.push_back({rd, exp});
   endtask

   task automatic idle();
      set_mem(1'b0, 1'b0, 1'b0, 3'd0, 2'd0, '0, '0, '0, '0);
   endtask

   initial begin
      reset    = 1'b0;
      Md_valid = 1'b1;
      Md_rd    = 5'd9;
      Md_data  = 32'h9999_9999;
      idle();

      // Reset held for two edges with a muldiv offer pending
      for (int i = 0; i < 2; i++) begin
         cyc();
         check("rst_write", 64'(Write), 64'(0));
         check("rst_md_ready", 64'(Md_ready), 64'(0));
         check("rst_pending", 64'(Md_pending), 64'(0));
      end
      check("rst_wreg", 64'(Write_register), 64'(0));
      check("rst_wdata", 64'(Write_data), 64'(0));
      reset    = 1'b1;
      Md_valid = 1'b0;
      #1;
      check("post_rst_md_ready", 64'(Md_ready), 64'(1));
      cyc();
      check("post_rst_pending", 64'(Md_pending), 64'(0));

      // Load extraction vectors
      set_mem(1, 1, 1, 3'd3, 2'd3, 5'd7, 32'h0, 32'h80FF_1234, 32'hFFFF_FF80); cyc();  // LB
      set_mem(1, 1, 1, 3'd4, 2'd3, 5'd7, 32'h0, 32'h80FF_1234, 32'h0000_0080); cyc();  // LBU
      set_mem(1, 1, 1, 3'd1, 2'd2, 5'd8, 32'h0, 32'h8001_0000, 32'hFFFF_8001); cyc();  // LH
      set_mem(1, 1, 1, 3'd1, 2'd2, 5'd0, 32'h0, 32'h8001_0000, 32'h0);         cyc();  // rd=0
      set_mem(1, 1, 1, 3'd2, 2'd0, 5'd9, 32'h0, 32'h1234_ABCD, 32'h0000_ABCD); cyc();  // LHU
      set_mem(1, 1, 1, 3'd3, 2'd1, 5'd9, 32'h0, 32'h1234_ABCD, 32'hFFFF_FFAB); cyc();  // LB lo=1
      set_mem(1, 1, 1, 3'd0, 2'd3, 5'd9, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D); cyc();  // LW
      set_mem(1, 1, 1, 3'd7, 2'd1, 5'd9, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF); cyc();  // undefined
      set_mem(1, 1, 0, 3'd3, 2'd1, 5'd10, 32'h1111_2222, 32'hDEAD_BEEF, 32'h1111_2222); cyc();
      set_mem(0, 1, 0, 3'd0, 2'd0, 5'd12, 32'h1212_1212, 32'h0, 32'h0);        cyc();  // bubble
      set_mem(1, 0, 0, 3'd0, 2'd0, 5'd12, 32'h1212_1212, 32'h0, 32'h0);        cyc();  // no RegWrite
      idle();
      cyc();

      // Muldiv results offered while the pipeline writes every cycle
      set_mem(1, 1, 0, 3'd0, 2'd0, 5'd20, 32'h2000_0020, 32'h0, 32'h2000_0020);
      Md_valid = 1'b1; Md_rd = 5'd3; Md_data = 32'h0000_0300;
      check("md_a_ready", 64'(Md_ready), 64'(1));
      cyc();
      set_mem(1, 1, 0, 3'd0, 2'd0, 5'd21, 32'h2000_0021, 32'h0, 32'h2000_0021);
      Md_rd = 5'd4; Md_data = 32'h0000_0400;
      check("md_b_ready", 64'(Md_ready), 64'(1));
      check("md_b_pending", 64'(Md_pending), 64'(1));
      cyc();
      set_mem(1, 1, 0, 3'd0, 2'd0, 5'd22, 32'h2000_0022, 32'h0, 32'h2000_0022);
      Md_rd = 5'd5; Md_data = 32'h0000_0500;
      check("md_c_ready_full", 64'(Md_ready), 64'(0));
      check("md_c_pending", 64'(Md_pending), 64'(2));
      cyc();
      idle();
      sb.push_back({5'd3, 32'h0000_0300});
      check("md_d_ready_full", 64'(Md_ready), 64'(0));
      check("md_d_pending", 64'(Md_pending), 64'(2));
      cyc();
      sb.push_back({5'd4, 32'h0000_0400});
      check("md_e_ready", 64'(Md_ready), 64'(1));
      check("md_e_pending", 64'(Md_pending), 64'(1));
      cyc();
      Md_valid = 1'b0;
      sb.push_back({5'd5, 32'h0000_0500});
      check("md_f_pending", 64'(Md_pending), 64'(1));
      cyc();
      check("md_g_pending", 64'(Md_pending), 64'(0));

      // Muldiv result for r0 is accepted and dropped
      Md_valid = 1'b1; Md_rd = 5'd0; Md_data = 32'h5555_5555;
      check("md_r0_ready", 64'(Md_ready), 64'(1));
      cyc();
      Md_valid = 1'b0;
      check("md_r0_pending", 64'(Md_pending), 64'(0));
      repeat (3) cyc();

      // Reset while two results are queued discards them
      set_mem(1, 1, 0, 3'd0, 2'd0, 5'd24, 32'h0000_0024, 32'h0, 32'h0000_0024);
      Md_valid = 1'b1; Md_rd = 5'd11; Md_data = 32'h0000_000B;
      cyc();
      set_mem(1, 1, 0, 3'd0, 2'd0, 5'd25, 32'h0000_0025, 32'h0, 32'h0000_0025);
      Md_rd = 5'd12; Md_data = 32'h0000_000C;
      cyc();
      check("pre_rst_pending", 64'(Md_pending), 64'(2));
      idle();
      Md_valid = 1'b0;
      reset    = 1'b0;
      #1;
      check("mid_rst_md_ready", 64'(Md_ready), 64'(0));
      cyc();
      check("mid_rst_write", 64'(Write), 64'(0));
      check("mid_rst_pending", 64'(Md_pending), 64'(0));
      check("mid_rst_wdata", 64'(Write_data), 64'(0));
      reset = 1'b1;
      repeat (4) cyc();

      check("sb_drained", 64'(sb.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final pipeline stage of the CPU. It registers MEM-stage results and extracts and extends load data, and it is the only driver of the register file's single write port (`Write`, `Write_register`, `Write_data`). A small FIFO holds results returned by the iterative multiply/divide unit. The main pipeline has strict priority on the write port, so the pipeline never stalls in WB.

## Interface
Parameters:
- `DATA_W`, 32, datapath width.
- `REG_W`, 5, register index width.
- `FIFO_DEPTH`, 2, muldiv result queue depth (power of two, ≥2).

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-low reset.
- `Mem_valid`  in  1  MEM stage holds a real instruction this cycle.
- `Mem_RegWrite`  in  1  instruction writes a register.
- `Mem_MemtoReg`  in  1  1 = result comes from load data, 0 = from `Mem_Result`.
- `Mem_LoadType`  in  3  load kind, encoded per `LT_*` constants.
- `Mem_Addr_lo`  in  2  byte offset of the load address.
- `Mem_rd`  in  REG_W  destination register.
- `Mem_Result`  in  DATA_W  ALU/link result.
- `Mem_ReadData`  in  DATA_W  raw aligned word from data memory.
- `Md_valid`  in  1  muldiv unit offers a result.
- `Md_ready`  out  1  queue can accept.
- `Md_rd`  in  REG_W  muldiv destination register.
- `Md_data`  in  DATA_W  muldiv result.
- `Md_pending`  out  $clog2(FIFO_DEPTH)+1  queued entries, for the hazard unit.
- `Write`  out  1  register-file write enable.
- `Write_register`  out  REG_W  register-file write index.
- `Write_data`  out  DATA_W  register-file write data.

## Operation
- Pipeline candidate: qualifies when `Mem_valid && Mem_RegWrite && Mem_rd != 0`.
- Candidate data:
  - When `Mem_MemtoReg = 0`, data is `Mem_Result`.
  - Otherwise the byte or halfword is selected by `Mem_Addr_lo` (little-endian) and extended:
    - LW: whole word; `Mem_Addr_lo` is ignored.
    - LH / LHU: halfword at `Addr_lo[1]`, sign- or zero-extended.
    - LB / LBU: byte at `Addr_lo`, sign- or zero-extended.
  - An undefined `LoadType` gives the whole word.
- Muldiv accept: accepted when `Md_valid && Md_ready`. Entries with `Md_rd == 0` are accepted and discarded (not queued).
- Arbitration, evaluated every cycle:
  - A qualifying pipeline candidate loads the output registers.
  - Otherwise, if the FIFO is non-empty, the head loads the output registers and is popped.
  - Otherwise `Write <= 0`; `Write_register` and `Write_data` hold their values.
- `Md_ready = reset && !full`. It depends on occupancy only: with the FIFO full, no push happens even if a pop occurs in the same cycle.
- Push and pop in the same cycle are allowed when the FIFO is not full; the count is unchanged.
- FIFO order is preserved; results retire in acceptance order.
- WAW between a queued muldiv result and a younger pipeline write to the same register cannot occur: the hazard unit blocks issue to any `rd` while `Md_pending != 0` for that register.

## Timing
- MEM inputs at cycle N → `Write*` at N+1 (outputs are registered).
- Muldiv accepted at N → earliest `Write*` at N+2 (no FIFO bypass). The entry is delayed one cycle per qualifying pipeline candidate.
- Starvation is bounded by the pipeline: any bubble or non-writing instruction drains one entry.
- While `reset` is low at a clock edge:
  - `Write = 0`, `Write_register = 0`, `Write_data = 0`.
  - FIFO emptied; `Md_pending = 0`.
  - `Md_ready = 0` (combinationally, while `reset` is low).
- Reset mid-drain discards all queued results; the CPU restarts from the reset vector.

## Configuration
- `WB_BYPASS_EN` defined: adds the following outputs, carrying the candidate being loaded into the output registers this cycle (combinational, pipeline or FIFO head) so EX can forward one cycle early:
  - `Fwd_valid`  out  1
  - `Fwd_register`  out  REG_W
  - `Fwd_data`  out  DATA_W
- `WB_BYPASS_EN` undefined: these ports and their logic are absent; forwarding comes from the register file's internal write-through only.

## Structure
- Shared package `cpu_pkg`:
  - `LT_LW=0`, `LT_LH=1`, `LT_LHU=2`, `LT_LB=3`, `LT_LBU=4`.
  - `DATA_W` and `REG_W` defaults.
- Sub-module `wb_fifo`: synchronous FIFO with parameters `DEPTH`/`WIDTH`, ports push/pop/full/empty/count and registered storage. `writeback_stage` instantiates it with `WIDTH = REG_W + DATA_W`.
- Load extraction is combinational logic inside `writeback_stage`.

## Test plan
- Reset low for 2 cycles with `Md_valid = 1` → `Write = 0`, `Md_ready = 0`, `Md_pending = 0`; after release `Md_ready = 1` and nothing is written.
- LB at `Addr_lo = 3`, `ReadData = 0x80FF_1234` → `Write_data = 0xFFFF_FF80` to `rd = 7` one cycle later. The same access with LBU → `0x0000_0080`.
- LH at `Addr_lo = 2`, `ReadData = 0x8001_0000` → `0xFFFF_8001`. With `Mem_rd = 0` → `Write = 0`.
- Three muldiv results (`rd` 3/4/5) offered back-to-back while the pipeline writes every cycle → third offer sees `Md_ready = 0`.
- Continuing that scenario, the pipeline then issues bubbles → writes of 3, 4, 5 in order at consecutive cycles, and `Md_pending` steps 2→1→0.
- Muldiv result with `Md_rd = 0` accepted → `Md_pending` stays 0 and no write follows.
